// File: rtl/mem_port_arbiter.sv
// Purpose : share one single-port memory between the fetch (I) and memory-stage (D) ports.
//           D has fixed priority. After MAX_D_STREAK back-to-back D grants while I waits,
//           the next grant goes to I.
// Latency : 2 + BUSY cycles from req to ready (minimum 3 cycles: IDLE, BUSY, RESP).
// Backpr. : requesters hold req until their one-cycle ready pulse. stall_f/stall_m are
//           asserted meanwhile. mem_req is held until mem_ack (or timeout, if built in).
// Ports   : clk/rst (async active-low); I port if_*; D port d_*; memory side mem_*;
//           stall_f/stall_m to hazard logic; err pulses on a timed-out access.
// Options : `define ARB_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles without mem_ack.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_port_arbiter: MAX_D_STREAK must be 1..15 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state;
    logic       owner;      // 0 = I, 1 = D
    logic [3:0] d_streak;
    logic       grant_d;

`ifdef ARB_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    // Compare against TIMEOUT-1: the check happens during the TIMEOUT-th BUSY cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    // D wins unless I is waiting and D has used up its streak allowance.
    assign grant_d = d_req && !(if_req && (d_streak == STREAK_MAX));

    assign stall_f = if_req & ~if_ready;
    assign stall_m = d_req & ~d_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            d_streak  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner     <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY;
                        // The streak only counts D grants that made I wait.
                        if (!if_req)
                            d_streak <= '0;
                        else if (d_streak != STREAK_MAX)
                            d_streak <= d_streak + 4'd1;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end else if (if_req) begin
                        owner     <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY;
                        d_streak  <= '0;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        if (owner) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // A same-cycle mem_ack already took the branch above.
                    else if (tmo_cnt == TMO_LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        err     <= 1'b1;
                        if (owner) begin
                            d_rdata <= '0;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                // No arbitration here: the owner's req is still up during its ready cycle.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {30'd0, stall_f, stall_m}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // ---- I read of 0x10, zero-wait ack ----
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("t1_c1_stall_f", {31'd0, stall_f}, 32'd1);
        chk("t1_c1_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("t1_c2_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_c2_mem_addr", mem_addr, 32'h10);
        chk("t1_c2_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t1_c2_stall_f", {31'd0, stall_f}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("t1_c3_if_ready", {31'd0, if_ready}, 32'd1);
        chk("t1_c3_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_c3_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t1_c3_stall_f", {31'd0, stall_f}, 32'd0);
        chk("t1_c3_d_ready", {31'd0, d_ready}, 32'd0);
        if_req = 1'b0;
        step();
        chk("t1_c4_if_ready", {31'd0, if_ready}, 32'd0);
        chk("t1_c4_if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // ---- simultaneous I read 0x30 and D store 0x55 -> 0x20 ----
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
        step();
        chk("t2_d_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t2_d_mem_addr", mem_addr, 32'h20);
        chk("t2_d_mem_wdata", mem_wdata, 32'h55);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_ack = 1'b0;
        chk("t2_d_ready", {31'd0, d_ready}, 32'd1);
        chk("t2_d_rdata", d_rdata, 32'h1234);
        chk("t2_if_ready_low", {31'd0, if_ready}, 32'd0);
        chk("t2_stall_m", {31'd0, stall_m}, 32'd0);
        chk("t2_stall_f", {31'd0, stall_f}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("t2_no_grant_in_resp", {31'd0, mem_req}, 32'd0);
        chk("t2_d_ready_low", {31'd0, d_ready}, 32'd0);
        step();
        chk("t2_i_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t2_i_mem_addr", mem_addr, 32'h30);
        chk("t2_i_mem_we", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        step();
        mem_ack = 1'b0;
        chk("t2_if_ready", {31'd0, if_ready}, 32'd1);
        chk("t2_if_rdata", if_rdata, 32'hCAFE0001);
        if_req = 1'b0;
        step();

        // ---- both held: D,D,D,D,I,D,D,D,D,I ----
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t3_grant%0d_addr", i), mem_addr, exp_d[i] ? 32'h40 : 32'h80);
            mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(i);
            step();
            mem_ack = 1'b0;
            chk($sformatf("t3_grant%0d_ready", i), {30'd0, d_ready, if_ready},
                exp_d[i] ? 32'd2 : 32'd1);
            if (i == 9) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            step();
        end
        chk("t3_last_d_rdata", d_rdata, 32'h108);
        chk("t3_last_if_rdata", if_rdata, 32'h109);

        // ---- I read with ack on the 5th BUSY cycle: ready on cycle 7 ----
        if_req = 1'b1; if_addr = 32'hA0;
        step();
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t4_busy%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("t4_busy%0d_if_ready", i), {31'd0, if_ready}, 32'd0);
            if (i == 5) begin
                mem_ack = 1'b1; mem_rdata = 32'h0A0A0A0A;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("t4_c7_if_ready", {31'd0, if_ready}, 32'd1);
        chk("t4_c7_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t4_c7_if_rdata", if_rdata, 32'h0A0A0A0A);
        if_req = 1'b0;
        step();

        // ---- async reset in the middle of BUSY ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h77;
        step();
        chk("t5_busy_mem_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t5_rst_mem_addr", mem_addr, 32'd0);
        chk("t5_rst_mem_wdata", mem_wdata, 32'd0);
        chk("t5_rst_if_rdata", if_rdata, 32'd0);
        chk("t5_rst_d_rdata", d_rdata, 32'd0);
        chk("t5_rst_ready_err", {29'd0, if_ready, d_ready, err}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        step();
        chk("t5_stale_ready", {30'd0, d_ready, if_ready}, 32'd0);
        chk("t5_stale_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        mem_ack = 1'b0;
        chk("t5_stale_d_rdata", d_rdata, 32'd0);
        d_req = 1'b1; d_addr = 32'h90;
        step();
        chk("t5_next_mem_addr", mem_addr, 32'h90);
        chk("t5_next_mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        chk("t5_next_d_ready", {31'd0, d_ready}, 32'd1);
        chk("t5_next_d_rdata", d_rdata, 32'h0BADF00D);
        d_req = 1'b0;
        step();

        // ---- no ack for 8 BUSY cycles ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        step();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t6_busy%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("t6_busy%0d_err", i), {31'd0, err}, 32'd0);
            step();
        end
`ifdef ARB_TIMEOUT_EN
        chk("t6_tmo_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t6_tmo_d_ready", {31'd0, d_ready}, 32'd1);
        chk("t6_tmo_d_rdata", d_rdata, 32'd0);
        chk("t6_tmo_err", {31'd0, err}, 32'd1);
        d_req = 1'b0;
        step();
        chk("t6_err_pulse", {31'd0, err}, 32'd0);
        chk("t6_ready_pulse", {31'd0, d_ready}, 32'd0);
        // ack on the 8th BUSY cycle beats the timeout
        d_req = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t6b_busy%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
            if (i == 8) begin
                mem_ack = 1'b1; mem_rdata = 32'h5A5A;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("t6b_d_ready", {31'd0, d_ready}, 32'd1);
        chk("t6b_d_rdata", d_rdata, 32'h5A5A);
        chk("t6b_err", {31'd0, err}, 32'd0);
        d_req = 1'b0;
        step();
`else
        chk("t6_hold_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t6_hold_d_ready", {31'd0, d_ready}, 32'd0);
        chk("t6_hold_err", {31'd0, err}, 32'd0);
        repeat (20) step();
        chk("t6_long_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t6_long_err", {31'd0, err}, 32'd0);
        chk("t6_long_d_rdata", d_rdata, 32'h0BADF00D);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A;
        step();
        mem_ack = 1'b0;
        chk("t6_late_d_ready", {31'd0, d_ready}, 32'd1);
        chk("t6_late_d_rdata", d_rdata, 32'h5A5A);
        chk("t6_late_err", {31'd0, err}, 32'd0);
        d_req = 1'b0;
        step();
`endif
        chk("end_mem_req", {31'd0, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
